// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue
//   Instruction-fetch front end. It keeps a fetch PC and issues one word
//   request at a time to instruction memory over a req/ack handshake, which
//   may take several cycles. Returned words are queued with their PC in a
//   DEPTH-entry FIFO and handed to decode over a valid/ready handshake.
//   A redirect flushes the queue, restarts fetch at the new PC and drops
//   the in-flight fetch if one is still pending.
//
// Parameters
//   XLEN      address / PC width
//   ILEN      instruction width
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset (word aligned)
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   imem_req        fetch request (registered)
//   imem_addr       fetch address, held while imem_req is high
//   imem_ack        request complete, imem_rdata valid this cycle
//   imem_rdata      fetched instruction
//   redirect_valid  flush and restart at redirect_pc
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   out_valid       head entry valid
//   out_ready       decode accepts head
//   out_inst        head instruction
//   out_pc          head PC
//   out_pc4         head PC + 4 (wraps)
//   count           FIFO occupancy
//
// Build option
//   FETCH_BYPASS_EN  when defined, an ack arriving into an empty queue is
//                    presented to decode in the same cycle and, if taken,
//                    never written to the FIFO.

module riscv_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [ILEN-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ILEN-1:0]          out_inst,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ILEN-1:0] instMem [DEPTH];
  logic [XLEN-1:0] pcMem   [DEPTH];

  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [CW-1:0]   countQ;
  logic [CW-1:0]   countNext;
  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] fetchPcNext;
  logic            discard;
  logic            discardNext;

  logic ackEff;
  logic outstanding;
  logic fifoEmpty;
  logic bypassHit;
  logic fire;
  logic pushEff;
  logic popFifo;
  logic canIssue;
  logic unusedRedirectLsb;

  // A late ack while no request is open (e.g. just after reset) is ignored.
  assign ackEff      = imem_req & imem_ack;
  assign outstanding = imem_req & ~imem_ack;
  assign fifoEmpty   = (countQ == '0);

`ifdef FETCH_BYPASS_EN
  assign bypassHit = ackEff & ~discard & ~redirect_valid & fifoEmpty;
  assign out_inst  = bypassHit ? imem_rdata : instMem[rdPtr];
  assign out_pc    = bypassHit ? imem_addr  : pcMem[rdPtr];
`else
  assign bypassHit = 1'b0;
  assign out_inst  = instMem[rdPtr];
  assign out_pc    = pcMem[rdPtr];
`endif

  assign out_pc4   = out_pc + XLEN'(4);
  assign out_valid = ~redirect_valid & (~fifoEmpty | bypassHit);
  assign fire      = out_valid & out_ready;

  // A bypassed word that decode takes immediately never occupies a slot.
  assign pushEff = ackEff & ~discard & ~redirect_valid & ~(bypassHit & out_ready);
  assign popFifo = fire & ~fifoEmpty;
  assign count   = countQ;

  assign unusedRedirectLsb = &redirect_pc[1:0];

  always_comb begin
    countNext = countQ;
    if (redirect_valid) begin
      countNext = '0;
    end else if (pushEff && !popFifo) begin
      countNext = countQ + CW'(1);
    end else if (!pushEff && popFifo) begin
      countNext = countQ - CW'(1);
    end
  end

  always_comb begin
    fetchPcNext = fetchPc;
    if (redirect_valid) begin
      fetchPcNext = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (ackEff && !discard) begin
      fetchPcNext = imem_addr + XLEN'(4);
    end
  end

  // Discard marks the open request as stale; it clears on that request's ack.
  always_comb begin
    discardNext = discard;
    if (redirect_valid) begin
      discardNext = outstanding;
    end else if (ackEff) begin
      discardNext = 1'b0;
    end
  end

  // Issuing only when a slot remains after this cycle's push/pop reserves
  // room for the returning word, so the FIFO can never overflow.
  assign canIssue = ~outstanding & (countNext < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetchPc   <= RESET_PC;
      discard   <= 1'b0;
      countQ    <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else begin
      fetchPc <= fetchPcNext;
      discard <= discardNext;
      countQ  <= countNext;
      if (redirect_valid) begin
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (pushEff) wrPtr <= wrPtr + AW'(1);
        if (popFifo) rdPtr <= rdPtr + AW'(1);
      end
      // Request and address stay frozen until the memory acknowledges.
      if (!outstanding) begin
        if (canIssue) begin
          imem_req  <= 1'b1;
          imem_addr <= fetchPcNext;
        end else begin
          imem_req  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushEff) begin
      instMem[wrPtr] <= imem_rdata;
      pcMem[wrPtr]   <= imem_addr;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
module tb_riscv_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        memAck = 1'b0;
  logic        strayAck = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [2:0]  count;

  int          errors = 0;
  int          checks = 0;
  int          memLat = 1;
  int          reqAge = 0;
  logic [31:0] sbQ[$];
  logic [31:0] expPc;

  assign imem_ack = memAck | strayAck;

  riscv_fetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pc4(out_pc4),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: ack in the memLat-th cycle of each request.
  always @(posedge clk) begin
    #1;
    if (memAck) reqAge = 0;
    if (!imem_req) begin
      reqAge = 0;
      memAck = 1'b0;
    end else begin
      reqAge++;
      memAck     = (reqAge >= memLat);
      imem_rdata = instOf(imem_addr);
    end
  end

  // Scoreboard monitor: every accepted head entry must match the next expected PC.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected delivery: got out_pc %h expected none", out_pc);
      end else begin
        expPc = sbQ.pop_front();
        check("out_pc", out_pc, expPc);
        check("out_pc4", out_pc4, expPc + 32'd4);
        check("out_inst", out_inst, instOf(expPc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    strayAck = 1'b0;
    sbQ.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d entries left expected 0", name, sbQ.size());
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming with single-cycle memory.
    memLat = 1;
    doReset();
    check("reset req", 32'(imem_req), 32'd0);
    check("reset addr", imem_addr, 32'h100);
    check("reset count", 32'(count), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) sbQ.push_back(32'h100 + 32'(4 * i));
    for (int i = 0; i < 6; i++) begin
      step();
      check("stream req", 32'(imem_req), 32'd1);
      check("stream addr", imem_addr, 32'h100 + 32'(4 * i));
`ifndef FETCH_BYPASS_EN
      if (i >= 1) check("stream count", 32'(count), 32'd1);
`endif
    end
    waitDrain("stream");

    // Back-pressure fills exactly DEPTH entries.
    memLat = 1;
    doReset();
    for (int i = 0; i < 8; i++) step();
    check("full count", 32'(count), 32'd4);
    check("full req", 32'(imem_req), 32'd0);
    check("full valid", 32'(out_valid), 32'd1);
    check("full head", out_pc, 32'h100);
    for (int i = 0; i < 8; i++) sbQ.push_back(32'h100 + 32'(4 * i));
    out_ready = 1'b1;
    waitDrain("resume");

    // Redirect while a 3-cycle fetch is pending.
    memLat = 3;
    doReset();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    check("redir0 addr", imem_addr, 32'h10);
    check("redir0 req", 32'(imem_req), 32'd1);
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    check("pending addr held", imem_addr, 32'h10);
    check("pending req held", 32'(imem_req), 32'd1);
    step();
    check("pending count", 32'(count), 32'd0);
    step();
    check("refetch addr", imem_addr, 32'h200);
    check("refetch req", 32'(imem_req), 32'd1);
    check("discard count", 32'(count), 32'd0);
    check("discard valid", 32'(out_valid), 32'd0);
    sbQ.push_back(32'h200);
    sbQ.push_back(32'h204);
    step();
    check("empty wait valid", 32'(out_valid), 32'd0);
    waitDrain("redirect");

    // Redirect coincident with an ack and a ready head entry.
    memLat = 1;
    doReset();
    out_ready = 1'b1;
`ifdef FETCH_BYPASS_EN
    sbQ.push_back(32'h100);
`endif
    sbQ.push_back(32'h300);
    sbQ.push_back(32'h304);
    sbQ.push_back(32'h308);
    step();
    step();
`ifndef FETCH_BYPASS_EN
    check("pre-redirect count", 32'(count), 32'd1);
`endif
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    check("redirect masks valid", 32'(out_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    check("flush count", 32'(count), 32'd0);
    check("flush addr", imem_addr, 32'h300);
    check("flush req", 32'(imem_req), 32'd1);
    waitDrain("coincident");

    // PC wrap at the top of the address space.
    memLat = 1;
    doReset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap next addr", imem_addr, 32'h0);
    check("wrap valid", 32'(out_valid), 32'd1);
    check("wrap pc", out_pc, 32'hFFFF_FFFC);
    check("wrap pc4", out_pc4, 32'h0);
    sbQ.push_back(32'hFFFF_FFFC);
    sbQ.push_back(32'h0);
    sbQ.push_back(32'h4);
    out_ready = 1'b1;
    waitDrain("wrap");

    // Reset with a request outstanding and two entries queued.
    memLat = 3;
    doReset();
    for (int i = 0; i < 7; i++) step();
    check("pre-rst count", 32'(count), 32'd2);
    check("pre-rst req", 32'(imem_req), 32'd1);
    check("pre-rst addr", imem_addr, 32'h108);
    rst = 1'b1;
    sbQ.delete();
    step();
    check("rst count", 32'(count), 32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    strayAck = 1'b1;
    step();
    strayAck = 1'b0;
    check("stray count", 32'(count), 32'd0);
    check("stray valid", 32'(out_valid), 32'd0);
    check("stray req", 32'(imem_req), 32'd1);
    check("stray addr", imem_addr, 32'h100);
    sbQ.push_back(32'h100);
    sbQ.push_back(32'h104);
    out_ready = 1'b1;
    waitDrain("post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
